hilo_muldiv: RTL and testbench

Multiply/divide unit holding the HI/LO special registers. It sits downstream of the main decoder in the execute stage. It receives decoded multiply, divide and move-to-HI/LO requests with the two register-file operands, and produces the HI/LO values consumed by mfhi/mflo. Divides are iterative, and multiplies are single-cycle or iterative depending on configuration. `busy` is the stall request the datapath uses to freeze PC and register writes.

---
 rtl/hilo_muldiv.sv | 170 +++++++++++++++++
 tb/tb_hilo_muldiv.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multiply/divide unit owning the HI/LO special registers.
//
// Accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO requests while idle. Divides use a
// restoring radix-2 loop, one quotient bit per cycle. Multiplies use a
// shift-add loop with the same WIDTH-cycle timing. Operands are reduced to
// magnitudes at acceptance and the sign is fixed up in a final commit cycle.
//
// Optional feature macro: MULDIV_FAST_MULT_EN. When it is defined, MULT/MULTU
// take the full product from the synthesis multiplier at acceptance and
// commit one cycle later. Divide timing does not change.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset
//   start_i  request strobe, only sampled while idle
//   op_i     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a_i      rs operand (dividend / multiplicand / MTHI-MTLO source)
//   b_i      rt operand (divisor / multiplier)
//   hi_o     HI register
//   lo_o     LO register
//   busy_o   high while a mul/div is in flight (stall request)
//   done_o   one-cycle pulse after a mul/div result is committed
module hilo_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_q;     // partial remainder / product high half
  logic [WIDTH-1:0] sh_q;      // dividend->quotient / multiplier->product low half
  logic [WIDTH-1:0] opnd_q;    // divisor or multiplicand magnitude
  logic [WIDTH-1:0] a_orig_q;  // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_div_q, div0_q, qneg_q, rneg_q, done_q;

  // Request decode
  logic op_signed, op_muldiv, op_is_div, op_mthi, op_mtlo;
  assign op_signed = ~op_i[0];
  assign op_muldiv = ~op_i[2];
  assign op_is_div = op_i[1];
  assign op_mthi   = (op_i == 3'b100);
  assign op_mtlo   = (op_i == 3'b101);

  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

  // One iteration of the restoring divide or shift-add multiply
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] acc_step, sh_step;
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, opnd_q & {WIDTH{sh_q[0]}}};
    div_shift = {acc_q, sh_q[WIDTH-1]};
    // Partial remainder is always below the divisor, so the MSB of the
    // (WIDTH+1)-bit difference is a clean borrow flag.
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      sh_step  = {sh_q[WIDTH-2:0], ~div_diff[WIDTH]};
      acc_step = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    end else begin
      {acc_step, sh_step} = {mul_sum, sh_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and result selection for the commit cycle
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, hi_fix, lo_fix;
  always_comb begin
    prod_fix = qneg_q ? -{acc_q, sh_q} : {acc_q, sh_q};
    quot_fix = qneg_q ? -sh_q : sh_q;
    rem_fix  = rneg_q ? -acc_q : acc_q;
    if (!is_div_q) begin
      {hi_fix, lo_fix} = prod_fix;
    end else if (div0_q) begin
      hi_fix = a_orig_q;
      lo_fix = '1;
    end else begin
      hi_fix = rem_fix;
      lo_fix = quot_fix;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      a_orig_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (op_mthi) begin
              hi_q <= a_i;
            end else if (op_mtlo) begin
              lo_q <= a_i;
            end else if (op_muldiv) begin
              is_div_q <= op_is_div;
              div0_q   <= (b_i == '0);
              qneg_q   <= op_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              rneg_q   <= op_signed & a_i[WIDTH-1];
              a_orig_q <= a_i;
              acc_q    <= '0;
              opnd_q   <= op_is_div ? b_mag : a_mag;
              sh_q     <= op_is_div ? a_mag : b_mag;
              cnt_q    <= '0;
              state_q  <= StRun;
`ifdef MULDIV_FAST_MULT_EN
              if (!op_is_div) begin
                {acc_q, sh_q} <= fast_prod;
                state_q       <= StFix;
              end
`endif
            end
          end
        end
        StRun: begin
          acc_q <= acc_step;
          sh_q  <= sh_step;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: scoreboard of expected HI/LO/latency,
// popped whenever the DUT pulses done.
module tb_hilo_muldiv;

  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  logic         clk_i   = 1'b0;
  logic         rst_ni  = 1'b0;
  logic         start_i = 1'b0;
  logic [2:0]   op_i    = 3'b110;
  logic [W-1:0] a_i     = '0;
  logic [W-1:0] b_i     = '0;
  logic [W-1:0] hi_o, lo_o;
  logic         busy_o, done_o;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(start_i),
    .op_i   (op_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .hi_o   (hi_o),
    .lo_o   (lo_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model built on native 64-bit arithmetic
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] eh,
                                output logic [W-1:0] el);
    longint     sa, sbv, q, r;
    logic [63:0] u;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    eh  = '0;
    el  = '0;
    case (op)
      3'd0: begin u = 64'(sa * sbv); {eh, el} = u; end
      3'd1: begin u = {32'd0, a} * {32'd0, b}; {eh, el} = u; end
      3'd2, 3'd3: begin
        if (b == '0) begin
          eh = a;
          el = '1;
        end else if (op == 3'd2) begin
          q  = sa / sbv;
          r  = sa % sbv;
          el = q[W-1:0];
          eh = r[W-1:0];
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Monitor: count busy cycles, pop and compare on each done pulse
  always begin
    @(posedge clk_i);
    #1;
    if (rst_ni) begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check({mon_e.tag, "_hi"}, 64'(hi_o), 64'(mon_e.hi));
          check({mon_e.tag, "_lo"}, 64'(lo_o), 64'(mon_e.lo));
          check({mon_e.tag, "_lat"}, 64'(busy_cnt), 64'(mon_e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input int lat);
    exp_t e;
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    e.tag = tag;
    e.hi  = eh;
    e.lo  = el;
    e.lat = lat;
    exp_q.push_back(e);
    @(negedge clk_i);
    // Scramble inputs so a DUT that fails to latch operands is caught
    start_i = 1'b0;
    op_i    = 3'($urandom_range(0, 3));
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  task automatic issue_model(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    model(op, a, b, eh, el);
    issue(tag, op, a, b, eh, el, op[1] ? DivLat : MulLat);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_i);
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic pulse_start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(negedge clk_i);
    start_i = 1'b0;
    op_i    = 3'b110;
  endtask

  initial begin
    int saved_done;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);

    // Move-to-HI/LO: visible one cycle later, no stall
    pulse_start(3'b100, 32'h1234_5678, 32'h0);
    check("mthi_hi", 64'(hi_o), 64'h1234_5678);
    check("mthi_lo", 64'(lo_o), 64'd0);
    check("mthi_busy", 64'(busy_o), 64'd0);
    check("mthi_done", 64'(done_o), 64'd0);
    pulse_start(3'b101, 32'hA5A5_A5A5, 32'h0);
    check("mtlo_lo", 64'(lo_o), 64'hA5A5_A5A5);
    check("mtlo_hi", 64'(hi_o), 64'h1234_5678);
    check("mt_busy_cycles", 64'(busy_cnt), 64'd0);

    issue("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, DivLat);
    drain();
    issue("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivLat);
    drain();
    issue("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DivLat);
    drain();

    // Divide by zero, with starts issued mid-flight that must be ignored
    issue("div_by0", 3'b010, 32'h55, 32'h0, 32'h55, 32'hFFFF_FFFF, DivLat);
    repeat (4) @(negedge clk_i);
    check("run_hold_hi", 64'(hi_o), 64'h0);
    check("run_hold_lo", 64'(lo_o), 64'h8000_0000);
    check("run_busy", 64'(busy_o), 64'd1);
    pulse_start(3'b100, 32'hDEAD_BEEF, 32'h0);
    pulse_start(3'b011, 32'd10, 32'd2);
    check("busy_mthi_ignored", 64'(hi_o), 64'h0);
    drain();
    issue("divu_by0", 3'b011, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, DivLat);
    drain();

    issue("mult_m1_3", 3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, MulLat);
    drain();
    issue("multu_m1_3", 3'b001, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, 32'hFFFF_FFFD, MulLat);
    drain();

    for (int k = 0; k < 12; k++) begin
      issue_model($sformatf("rnd%0d", k), 3'(k % 4), $urandom,
                  (k == 7) ? 32'h0 : 32'($urandom));
      drain();
    end

    // Reset in the middle of a DIVU: aborted result is never written
    pulse_start(3'b100, 32'h0BAD_F00D, 32'h0);
    pulse_start(3'b101, 32'h1357_9BDF, 32'h0);
    pulse_start(3'b011, 32'd1000, 32'd3);
    repeat (8) @(negedge clk_i);
    check("midop_busy", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("abort_hi", 64'(hi_o), 64'd0);
    check("abort_lo", 64'(lo_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni     = 1'b1;
    busy_cnt   = 0;
    saved_done = done_cnt;
    repeat (40) @(negedge clk_i);
    check("abort_no_done", 64'(done_cnt), 64'(saved_done));
    check("abort_hi_after", 64'(hi_o), 64'd0);
    check("abort_lo_after", 64'(lo_o), 64'd0);
    check("abort_idle_busy", 64'(busy_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures",
             n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
